// File: rtl/robo_odometria_if.sv
// Command/pose bundle between the wall-following FSM (master) and the odometry tracker (slave).
// ODOM_LOOP_DETECT_EN adds the ciclo_o flag; no backpressure, commands are qualified by amostra_i.
interface robo_odometria_if #(
  parameter int W_POS = 5,
  parameter int W_MOV = 8
);
  logic             carregar_i;
  logic [W_POS-1:0] lin_ini_i;
  logic [W_POS-1:0] col_ini_i;
  logic [1:0]       ori_ini_i;
  logic             amostra_i;
  logic             avancar_i;
  logic             girar_i;
  logic [W_POS-1:0] linha_o;
  logic [W_POS-1:0] coluna_o;
  logic [1:0]       orientacao_o;
  logic [W_MOV-1:0] qtd_mov_o;
  logic             ativo_o;
  logic             erro_o;
  logic             fim_o;
`ifdef ODOM_LOOP_DETECT_EN
  logic             ciclo_o;

  modport master (
    output carregar_i, lin_ini_i, col_ini_i, ori_ini_i, amostra_i, avancar_i, girar_i,
    input  linha_o, coluna_o, orientacao_o, qtd_mov_o, ativo_o, erro_o, fim_o, ciclo_o
  );
  modport slave (
    input  carregar_i, lin_ini_i, col_ini_i, ori_ini_i, amostra_i, avancar_i, girar_i,
    output linha_o, coluna_o, orientacao_o, qtd_mov_o, ativo_o, erro_o, fim_o, ciclo_o
  );
`else
  modport master (
    output carregar_i, lin_ini_i, col_ini_i, ori_ini_i, amostra_i, avancar_i, girar_i,
    input  linha_o, coluna_o, orientacao_o, qtd_mov_o, ativo_o, erro_o, fim_o
  );
  modport slave (
    input  carregar_i, lin_ini_i, col_ini_i, ori_ini_i, amostra_i, avancar_i, girar_i,
    output linha_o, coluna_o, orientacao_o, qtd_mov_o, ativo_o, erro_o, fim_o
  );
`endif
endinterface

// File: rtl/robo_odometria.sv
// Robot pose tracker (row/col/orientation/move count) with sticky erro/fim; latency 1 clk, no backpressure.
// Optional ODOM_LOOP_DETECT_EN: a move returning to the loaded pose sets ciclo and ends tracking.
module robo_odometria #(
  parameter int GRID    = 20,
  parameter int W_POS   = 5,
  parameter int W_MOV   = 8,
  parameter int MAX_MOV = 255
) (
  input  logic             clk,
  input  logic             rst,
  robo_odometria_if.slave  bus
);

  localparam logic [1:0] PARADO = 2'd0;
  localparam logic [1:0] ATIVO  = 2'd1;
  localparam logic [1:0] ERRO   = 2'd2;
  localparam logic [1:0] FIM    = 2'd3;

  localparam logic [1:0] ORI_N = 2'b00;
  localparam logic [1:0] ORI_S = 2'b01;
  localparam logic [1:0] ORI_L = 2'b10;
  localparam logic [1:0] ORI_O = 2'b11;

  localparam logic [W_POS-1:0] POS_MIN = W_POS'(1);
  localparam logic [W_POS-1:0] POS_MAX = W_POS'(GRID);
  localparam logic [W_MOV-1:0] MOV_LIM = W_MOV'(MAX_MOV);

  logic [1:0]       state_q, state_d;
  logic [W_POS-1:0] lin_q, lin_d;
  logic [W_POS-1:0] col_q, col_d;
  logic [1:0]       ori_q, ori_d;
  logic [W_MOV-1:0] mov_q, mov_d;
  logic             erro_q, erro_d;
  logic             fim_q, fim_d;

  logic             pose_ok;
  logic             cmd_vld;
  logic             fora;
  logic [W_POS-1:0] nxt_lin;
  logic [W_POS-1:0] nxt_col;
  logic [1:0]       nxt_ori;
  logic [W_MOV-1:0] nxt_mov;
  logic             esgotou;
  logic             volta;

`ifdef ODOM_LOOP_DETECT_EN
  logic [W_POS-1:0] lin0_q, lin0_d;
  logic [W_POS-1:0] col0_q, col0_d;
  logic [1:0]       ori0_q, ori0_d;
  logic             ciclo_q, ciclo_d;
`endif

  always_comb begin
    pose_ok = (bus.lin_ini_i >= POS_MIN) && (bus.lin_ini_i <= POS_MAX) &&
              (bus.col_ini_i >= POS_MIN) && (bus.col_ini_i <= POS_MAX);
  end

  assign cmd_vld = (state_q == ATIVO) && bus.amostra_i && (bus.avancar_i || bus.girar_i);

  // Candidate pose for this cycle's command; avancar wins over girar.
  always_comb begin
    nxt_lin = lin_q;
    nxt_col = col_q;
    nxt_ori = ori_q;
    fora    = 1'b0;
    if (bus.avancar_i) begin
      unique case (ori_q)
        ORI_N: if (lin_q <= POS_MIN) fora = 1'b1; else nxt_lin = lin_q - W_POS'(1);
        ORI_S: if (lin_q >= POS_MAX) fora = 1'b1; else nxt_lin = lin_q + W_POS'(1);
        ORI_L: if (col_q >= POS_MAX) fora = 1'b1; else nxt_col = col_q + W_POS'(1);
        default: if (col_q <= POS_MIN) fora = 1'b1; else nxt_col = col_q - W_POS'(1);
      endcase
    end else begin
      unique case (ori_q)
        ORI_N:   nxt_ori = ORI_O;
        ORI_O:   nxt_ori = ORI_S;
        ORI_S:   nxt_ori = ORI_L;
        default: nxt_ori = ORI_N;
      endcase
    end
  end

  // mov_q < MAX_MOV while ATIVO, so the increment cannot wrap.
  assign nxt_mov = mov_q + W_MOV'(1);
  assign esgotou = (nxt_mov == MOV_LIM);

`ifdef ODOM_LOOP_DETECT_EN
  assign volta = (nxt_lin == lin0_q) && (nxt_col == col0_q) && (nxt_ori == ori0_q);
`else
  assign volta = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    lin_d   = lin_q;
    col_d   = col_q;
    ori_d   = ori_q;
    mov_d   = mov_q;
    erro_d  = erro_q;
    fim_d   = fim_q;
`ifdef ODOM_LOOP_DETECT_EN
    lin0_d  = lin0_q;
    col0_d  = col0_q;
    ori0_d  = ori0_q;
    ciclo_d = ciclo_q;
`endif
    if (bus.carregar_i) begin
      lin_d   = bus.lin_ini_i;
      col_d   = bus.col_ini_i;
      ori_d   = bus.ori_ini_i;
      mov_d   = '0;
      fim_d   = 1'b0;
      erro_d  = !pose_ok;
      state_d = pose_ok ? ATIVO : ERRO;
`ifdef ODOM_LOOP_DETECT_EN
      lin0_d  = bus.lin_ini_i;
      col0_d  = bus.col_ini_i;
      ori0_d  = bus.ori_ini_i;
      ciclo_d = 1'b0;
`endif
    end else if (cmd_vld) begin
      if (fora) begin
        erro_d  = 1'b1;
        state_d = ERRO;
      end else begin
        lin_d = nxt_lin;
        col_d = nxt_col;
        ori_d = nxt_ori;
        mov_d = nxt_mov;
        if (esgotou || volta) begin
          fim_d   = 1'b1;
          state_d = FIM;
        end
`ifdef ODOM_LOOP_DETECT_EN
        if (volta) ciclo_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PARADO;
      lin_q   <= '0;
      col_q   <= '0;
      ori_q   <= ORI_N;
      mov_q   <= '0;
      erro_q  <= 1'b0;
      fim_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lin_q   <= lin_d;
      col_q   <= col_d;
      ori_q   <= ori_d;
      mov_q   <= mov_d;
      erro_q  <= erro_d;
      fim_q   <= fim_d;
    end
  end

`ifdef ODOM_LOOP_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lin0_q  <= '0;
      col0_q  <= '0;
      ori0_q  <= ORI_N;
      ciclo_q <= 1'b0;
    end else begin
      lin0_q  <= lin0_d;
      col0_q  <= col0_d;
      ori0_q  <= ori0_d;
      ciclo_q <= ciclo_d;
    end
  end

  assign bus.ciclo_o = ciclo_q;
`endif

  assign bus.linha_o      = lin_q;
  assign bus.coluna_o     = col_q;
  assign bus.orientacao_o = ori_q;
  assign bus.qtd_mov_o    = mov_q;
  assign bus.ativo_o      = (state_q == ATIVO);
  assign bus.erro_o       = erro_q;
  assign bus.fim_o        = fim_q;

endmodule

// File: tb/tb_robo_odometria.sv
// Directed and random checks of robo_odometria against a grid-walk reference model.
module tb_robo_odometria;
  localparam int GRID    = 20;
  localparam int W_POS   = 5;
  localparam int W_MOV   = 8;
  localparam int MAX_MOV = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  robo_odometria_if #(.W_POS(W_POS), .W_MOV(W_MOV)) bus ();

  robo_odometria #(.GRID(GRID), .W_POS(W_POS), .W_MOV(W_MOV), .MAX_MOV(MAX_MOV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: orientation codes N=0 S=1 L=2 O=3
  int dr [4] = '{-1, 1, 0, 0};
  int dc [4] = '{0, 0, 1, -1};
  int esq[4] = '{3, 2, 0, 1};
  int m_lin, m_col, m_ori, m_mov;
  int s_lin, s_col, s_ori;
  bit m_run, m_erro, m_fim, m_ciclo;
  bit loop_en;

  task automatic model_reset();
    m_lin = 0; m_col = 0; m_ori = 0; m_mov = 0;
    s_lin = 0; s_col = 0; s_ori = 0;
    m_run = 0; m_erro = 0; m_fim = 0; m_ciclo = 0;
  endtask

  task automatic model_step(input bit c, input int li, input int ci, input int oi,
                            input bit a, input bit av, input bit gi);
    int nr, nc, no;
    if (c) begin
      m_lin = li; m_col = ci; m_ori = oi; m_mov = 0;
      s_lin = li; s_col = ci; s_ori = oi;
      m_fim = 0; m_ciclo = 0;
      m_erro = !(li >= 1 && li <= GRID && ci >= 1 && ci <= GRID);
      m_run  = !m_erro;
    end else if (m_run && a && (av || gi)) begin
      nr = m_lin; nc = m_col; no = m_ori;
      if (av) begin
        nr = m_lin + dr[m_ori];
        nc = m_col + dc[m_ori];
      end else begin
        no = esq[m_ori];
      end
      if (nr < 1 || nr > GRID || nc < 1 || nc > GRID) begin
        m_erro = 1; m_run = 0;
      end else begin
        m_lin = nr; m_col = nc; m_ori = no; m_mov++;
        if (loop_en && nr == s_lin && nc == s_col && no == s_ori) m_ciclo = 1;
        if (m_mov == MAX_MOV || m_ciclo) begin
          m_fim = 1; m_run = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".linha"},      32'(bus.linha_o),      m_lin);
    chk({tag, ".coluna"},     32'(bus.coluna_o),     m_col);
    chk({tag, ".orientacao"}, 32'(bus.orientacao_o), m_ori);
    chk({tag, ".qtd_mov"},    32'(bus.qtd_mov_o),    m_mov);
    chk({tag, ".ativo"},      32'(bus.ativo_o),      32'(m_run));
    chk({tag, ".erro"},       32'(bus.erro_o),       32'(m_erro));
    chk({tag, ".fim"},        32'(bus.fim_o),        32'(m_fim));
`ifdef ODOM_LOOP_DETECT_EN
    chk({tag, ".ciclo"},      32'(bus.ciclo_o),      32'(m_ciclo));
`endif
  endtask

  task automatic cyc(input string tag, input bit c, input int li, input int ci, input int oi,
                     input bit a, input bit av, input bit gi);
    bus.carregar_i = c;
    bus.lin_ini_i  = W_POS'(li);
    bus.col_ini_i  = W_POS'(ci);
    bus.ori_ini_i  = 2'(oi);
    bus.amostra_i  = a;
    bus.avancar_i  = av;
    bus.girar_i    = gi;
    @(posedge clk);
    model_step(c, li, ci, oi, a, av, gi);
    #1;
    chk_all(tag);
  endtask

  task automatic load(input string tag, input int li, input int ci, input int oi);
    cyc(tag, 1'b1, li, ci, oi, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic adv(input string tag);
    cyc(tag, 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic rot(input string tag);
    cyc(tag, 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
  endtask

  int exp_ori[4] = '{0, 3, 1, 2};

  initial begin
`ifdef ODOM_LOOP_DETECT_EN
    loop_en = 1'b1;
`else
    loop_en = 1'b0;
`endif
    model_reset();
    bus.carregar_i = 0; bus.lin_ini_i = '0; bus.col_ini_i = '0; bus.ori_ini_i = '0;
    bus.amostra_i = 0; bus.avancar_i = 0; bus.girar_i = 0;
    #12;
    chk_all("reset");
    rst = 1'b0;

    // Async reset while tracking at (5,5,N)
    load("ld_5_5", 5, 5, 0);
    #3 rst = 1'b1;
    #1;
    chk("rst_async.linha",  32'(bus.linha_o),  0);
    chk("rst_async.coluna", 32'(bus.coluna_o), 0);
    chk("rst_async.ativo",  32'(bus.ativo_o),  0);
    model_reset();
    #2 rst = 1'b0;
    chk_all("rst_async");

    load("ld_10_10", 10, 10, 0);
    for (int i = 0; i < 3; i++) adv("adv_n");
    chk("adv3.linha",   32'(bus.linha_o),   7);
    chk("adv3.coluna",  32'(bus.coluna_o),  10);
    chk("adv3.qtd_mov", 32'(bus.qtd_mov_o), 3);
    chk("adv3.erro",    32'(bus.erro_o),    0);

    load("ld_1_4", 1, 4, 0);
    adv("adv_top_edge");
    chk("edge.linha",   32'(bus.linha_o),   1);
    chk("edge.qtd_mov", 32'(bus.qtd_mov_o), 0);
    chk("edge.erro",    32'(bus.erro_o),    1);
    chk("edge.ativo",   32'(bus.ativo_o),   0);

    load("ld_3_3_L", 3, 3, 2);
    for (int i = 0; i < 4; i++) begin
      rot("girar");
      chk("girar.ori", 32'(bus.orientacao_o), exp_ori[i]);
    end
    chk("girar4.qtd_mov", 32'(bus.qtd_mov_o), 4);
    cyc("both_high", 1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b1);
`ifdef ODOM_LOOP_DETECT_EN
    chk("both_high.coluna", 32'(bus.coluna_o), 3);
`else
    chk("both_high.coluna", 32'(bus.coluna_o), 4);
`endif

    load("ld_10_10_S", 10, 10, 1);
    for (int i = 0; i < 6; i++) adv("adv_s");
    chk("budget.linha",   32'(bus.linha_o),   15);
    chk("budget.qtd_mov", 32'(bus.qtd_mov_o), MAX_MOV);
    chk("budget.fim",     32'(bus.fim_o),     1);

    load("ld_0_7", 0, 7, 0);
    chk("bad_load.erro",  32'(bus.erro_o),  1);
    chk("bad_load.ativo", 32'(bus.ativo_o), 0);
    load("ld_2_2_S", 2, 2, 1);
    chk("reload.ativo", 32'(bus.ativo_o), 1);
    chk("reload.erro",  32'(bus.erro_o),  0);

    load("ld_20_20_S", GRID, GRID, 1);
    adv("adv_bottom_edge");
    chk("bottom.erro", 32'(bus.erro_o), 1);
    load("ld_21_5", GRID + 1, 5, 0);
    chk("bad_load21.erro", 32'(bus.erro_o), 1);

    // carregar wins over a simultaneous command
    cyc("load_and_cmd", 1'b1, 6, 6, 0, 1'b1, 1'b1, 1'b0);
    chk("load_and_cmd.linha", 32'(bus.linha_o), 6);
    cyc("idle_no_move", 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("idle.qtd_mov", 32'(bus.qtd_mov_o), 0);

`ifdef ODOM_LOOP_DETECT_EN
    load("ld_4_4_N", 4, 4, 0);
    for (int i = 0; i < 4; i++) rot("loop_girar");
    chk("loop.ciclo",   32'(bus.ciclo_o),   1);
    chk("loop.fim",     32'(bus.fim_o),     1);
    chk("loop.qtd_mov", 32'(bus.qtd_mov_o), 4);
`endif

    for (int i = 0; i < 600; i++) begin
      bit c, a, av, gi;
      int li, ci;
      c  = ($urandom_range(0, 9) == 0);
      li = ($urandom_range(0, 7) == 0) ? $urandom_range(0, GRID + 1) : $urandom_range(1, GRID);
      ci = ($urandom_range(0, 7) == 0) ? $urandom_range(0, GRID + 1) : $urandom_range(1, GRID);
      a  = ($urandom_range(0, 3) != 0);
      av = 1'($urandom_range(0, 1));
      gi = 1'($urandom_range(0, 1));
      cyc("rand", c, li, ci, $urandom_range(0, 3), a, av, gi);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
